// File: rtl/exu_pkg.sv
// Shared definitions for the 4-stage pipeline sequencer: opcodes, instruction
// field positions and the decoded-control bundle carried from ID into EX.
package exu_pkg;

  localparam logic [1:0] OPC_ADD  = 2'b00;
  localparam logic [1:0] OPC_SLLI = 2'b01;
  localparam logic [1:0] OPC_JMP  = 2'b10;
  localparam logic [1:0] OPC_NOP  = 2'b11;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 3;
  localparam int RS_HI  = 2;
  localparam int RS_LO  = 0;
  localparam int OFF_HI = 5;
  localparam int OFF_LO = 0;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic [2:0] rd;
    logic [2:0] rs;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [1:0] opcode_of(input logic [7:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/exu_pipeline_ctrl_if.sv
// Bundle of fetch-side inputs and stage-control outputs of the sequencer;
// the sequencer sits on the slave side, the core/bench on the master side.
interface exu_pipeline_ctrl_if #(
  parameter int RETIRE_W = 16
);

  logic                stall_i;
  logic                if_valid_i;
  logic [7:0]          if_instr_i;
  logic                retire_clr_i;
  logic                id_ex_alusrc_o;
  logic                id_ex_regwrite_o;
  logic [2:0]          id_ex_rd_o;
  logic [2:0]          id_ex_rs_o;
  logic                fwd_ctrl_o;
  logic                ex_wb_regwrite_o;
  logic [2:0]          ex_wb_rd_o;
  logic                pc_load_o;
  logic [5:0]          jump_off_o;
  logic                ifid_valid_o;
  logic [RETIRE_W-1:0] retire_cnt_o;

  modport master (
    output stall_i, if_valid_i, if_instr_i, retire_clr_i,
    input  id_ex_alusrc_o, id_ex_regwrite_o, id_ex_rd_o, id_ex_rs_o,
    input  fwd_ctrl_o, ex_wb_regwrite_o, ex_wb_rd_o,
    input  pc_load_o, jump_off_o, ifid_valid_o, retire_cnt_o
  );

  modport slave (
    input  stall_i, if_valid_i, if_instr_i, retire_clr_i,
    output id_ex_alusrc_o, id_ex_regwrite_o, id_ex_rd_o, id_ex_rs_o,
    output fwd_ctrl_o, ex_wb_regwrite_o, ex_wb_rd_o,
    output pc_load_o, jump_off_o, ifid_valid_o, retire_cnt_o
  );

endinterface

// File: rtl/exu_decode.sv
// Combinational ID-stage decoder: turns the IF/ID entry into ALU controls and
// flags whether it writes a register or requests a jump.
module exu_decode
  import exu_pkg::*;
(
  input  logic       valid,
  input  logic [7:0] instr,
  output ctrl_t      ctrl,
  output logic       writer,
  output logic       jump
);

  logic [1:0] op;

  assign op = opcode_of(instr);

  // Anything that is not a live add/slli leaves ID as an all-zero bubble.
  always_comb begin
    ctrl   = CTRL_BUBBLE;
    writer = valid && (op == OPC_ADD || op == OPC_SLLI);
    jump   = valid && (op == OPC_JMP);
    if (writer) begin
      ctrl.regwrite = 1'b1;
      ctrl.alusrc   = (op == OPC_SLLI);
      ctrl.rd       = instr[RD_HI:RD_LO];
      ctrl.rs       = instr[RS_HI:RS_LO];
    end
  end

endmodule

// File: rtl/exu_pipeline_ctrl.sv
// Pipeline sequencer for the IF/ID/EX/WB 8-bit core: stage registers, forwarding
// select, jump flush and a saturating retired-instruction counter.
module exu_pipeline_ctrl
  import exu_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  exu_pipeline_ctrl_if.slave bus
);

  logic                ifid_valid;
  logic [7:0]          ifid_instr;
  ctrl_t               id_ctrl;
  logic                id_writer;
  logic                id_jump;
  ctrl_t               id_ex;
  logic                fwd_ctrl;
  logic                ex_wb_regwrite;
  logic [2:0]          ex_wb_rd;
  logic [RETIRE_W-1:0] retire_cnt;
  logic                flush;

  exu_decode u_decode (
    .valid  (ifid_valid),
    .instr  (ifid_instr),
    .ctrl   (id_ctrl),
    .writer (id_writer),
    .jump   (id_jump)
  );

  // A stalled jump keeps waiting in ID, so the flush fires on the first free cycle.
  assign flush = id_jump & ~bus.stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid     <= 1'b0;
      ifid_instr     <= '0;
      id_ex          <= CTRL_BUBBLE;
      fwd_ctrl       <= 1'b0;
      ex_wb_regwrite <= 1'b0;
      ex_wb_rd       <= '0;
    end else if (!bus.stall_i) begin
      ifid_valid     <= bus.if_valid_i & ~flush;
      ifid_instr     <= bus.if_instr_i;
      id_ex          <= id_ctrl;
      fwd_ctrl       <= id_writer & id_ex.regwrite & (id_ctrl.rd == id_ex.rd);
      ex_wb_regwrite <= id_ex.regwrite;
      ex_wb_rd       <= id_ex.rd;
    end
  end

  // Clear wins over increment and is honoured even while the pipe is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (bus.retire_clr_i) begin
      retire_cnt <= '0;
    end else if (!bus.stall_i && ex_wb_regwrite && (retire_cnt != '1)) begin
      retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

  assign bus.pc_load_o        = flush;
  assign bus.jump_off_o       = flush ? ifid_instr[OFF_HI:OFF_LO] : 6'd0;
  assign bus.ifid_valid_o     = ifid_valid;
  assign bus.id_ex_alusrc_o   = id_ex.alusrc;
  assign bus.id_ex_regwrite_o = id_ex.regwrite;
  assign bus.id_ex_rd_o       = id_ex.rd;
  assign bus.id_ex_rs_o       = id_ex.rs;
  assign bus.fwd_ctrl_o       = fwd_ctrl;
  assign bus.ex_wb_regwrite_o = ex_wb_regwrite;
  assign bus.ex_wb_rd_o       = ex_wb_rd;
  assign bus.retire_cnt_o     = retire_cnt;

endmodule

// File: tb/tb_exu_pipeline_ctrl.sv
// Self-checking bench for exu_pipeline_ctrl: directed scenarios plus randomized
// traffic compared cycle by cycle against an instruction-level reference model.
module tb_exu_pipeline_ctrl;

  localparam int RW     = 4;
  localparam int CNTMAX = (1 << RW) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  exu_pipeline_ctrl_if #(.RETIRE_W(RW)) bus ();

  exu_pipeline_ctrl #(.RETIRE_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which instruction occupies each stage, plus the counter.
  bit         m_id_v;
  logic [7:0] m_id_i;
  bit         m_ex_rw;
  bit         m_ex_src;
  logic [2:0] m_ex_rd;
  logic [2:0] m_ex_rs;
  bit         m_fwd;
  bit         m_wb_rw;
  logic [2:0] m_wb_rd;
  int         m_cnt;

  function automatic bit writes_reg(input bit v, input logic [7:0] ins);
    return v && (ins[7:6] == 2'b00 || ins[7:6] == 2'b01);
  endfunction

  function automatic bit m_pc_load();
    return m_id_v && (m_id_i[7:6] == 2'b10) && !bus.stall_i;
  endfunction

  function automatic logic [5:0] m_jump_off();
    return m_pc_load() ? m_id_i[5:0] : 6'd0;
  endfunction

  task automatic model_reset();
    m_id_v = 0; m_id_i = '0; m_ex_rw = 0; m_ex_src = 0; m_ex_rd = '0; m_ex_rs = '0;
    m_fwd = 0; m_wb_rw = 0; m_wb_rd = '0; m_cnt = 0;
  endtask

  task automatic drive(input bit st, input bit v, input logic [7:0] ins, input bit clr);
    bus.stall_i      = st;
    bus.if_valid_i   = v;
    bus.if_instr_i   = ins;
    bus.retire_clr_i = clr;
    #1;
  endtask

  task automatic tick();
    bit         st, fl, w, v, clr;
    logic [7:0] ins;
    int         nc;
    st  = bus.stall_i;
    v   = bus.if_valid_i;
    ins = bus.if_instr_i;
    clr = bus.retire_clr_i;
    fl  = m_pc_load();
    w   = writes_reg(m_id_v, m_id_i);
    if (clr) nc = 0;
    else if (!st && m_wb_rw) nc = (m_cnt < CNTMAX) ? m_cnt + 1 : CNTMAX;
    else nc = m_cnt;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_cnt = nc;
      if (!st) begin
        m_wb_rw  = m_ex_rw;
        m_wb_rd  = m_ex_rd;
        m_fwd    = w && m_ex_rw && (m_id_i[5:3] == m_ex_rd);
        m_ex_rw  = w;
        m_ex_src = w && (m_id_i[7:6] == 2'b01);
        m_ex_rd  = w ? m_id_i[5:3] : 3'd0;
        m_ex_rs  = w ? m_id_i[2:0] : 3'd0;
        m_id_v   = v && !fl;
        m_id_i   = ins;
      end
    end
    #1;
  endtask

  task automatic drain();
    repeat (4) begin
      drive(0, 1, 8'hC0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1, 8'h13, 0);
    repeat (2) tick();
    n_checks++; if (bus.ifid_valid_o !== 1'b0) $display("[TB] FAIL rst ifid_valid got %0b exp 0", bus.ifid_valid_o); else n_pass++;
    n_checks++; if (bus.id_ex_regwrite_o !== 1'b0) $display("[TB] FAIL rst id_ex_regwrite got %0b exp 0", bus.id_ex_regwrite_o); else n_pass++;
    n_checks++; if ({bus.id_ex_rd_o, bus.id_ex_rs_o, bus.id_ex_alusrc_o} !== 7'd0) $display("[TB] FAIL rst id_ex fields got %0h exp 0", {bus.id_ex_rd_o, bus.id_ex_rs_o, bus.id_ex_alusrc_o}); else n_pass++;
    n_checks++; if ({bus.fwd_ctrl_o, bus.ex_wb_regwrite_o, bus.ex_wb_rd_o} !== 5'd0) $display("[TB] FAIL rst fwd/ex_wb got %0h exp 0", {bus.fwd_ctrl_o, bus.ex_wb_regwrite_o, bus.ex_wb_rd_o}); else n_pass++;
    n_checks++; if ({bus.pc_load_o, bus.jump_off_o} !== 7'd0) $display("[TB] FAIL rst pc_load/jump_off got %0h exp 0", {bus.pc_load_o, bus.jump_off_o}); else n_pass++;
    n_checks++; if (bus.retire_cnt_o !== 4'd0) $display("[TB] FAIL rst retire_cnt got %0d exp 0", bus.retire_cnt_o); else n_pass++;
    rst_n = 1'b1;
    drive(0, 1, 8'h13, 0);
    tick();
    n_checks++; if (bus.ifid_valid_o !== 1'b1) $display("[TB] FAIL rst_rel ifid_valid got %0b exp 1", bus.ifid_valid_o); else n_pass++;
    drive(0, 1, 8'hC0, 0);
    tick();
    n_checks++; if (bus.id_ex_regwrite_o !== 1'b1) $display("[TB] FAIL add regwrite got %0b exp 1", bus.id_ex_regwrite_o); else n_pass++;
    n_checks++; if (bus.id_ex_rd_o !== 3'd2) $display("[TB] FAIL add rd got %0d exp 2", bus.id_ex_rd_o); else n_pass++;
    n_checks++; if (bus.id_ex_rs_o !== 3'd3) $display("[TB] FAIL add rs got %0d exp 3", bus.id_ex_rs_o); else n_pass++;
    n_checks++; if (bus.id_ex_alusrc_o !== 1'b0) $display("[TB] FAIL add alusrc got %0b exp 0", bus.id_ex_alusrc_o); else n_pass++;
  endtask

  task automatic test_forward();
    drain();
    drive(0, 1, 8'h13, 0); tick();
    drive(0, 1, 8'h51, 0); tick();
    drive(0, 1, 8'hC0, 0); tick();
    n_checks++; if (bus.fwd_ctrl_o !== 1'b1) $display("[TB] FAIL fwd_b2b got %0b exp 1", bus.fwd_ctrl_o); else n_pass++;
    n_checks++; if ({bus.id_ex_alusrc_o, bus.id_ex_rd_o, bus.id_ex_rs_o} !== {1'b1, 3'd2, 3'd1}) $display("[TB] FAIL slli_ex got %0h exp %0h", {bus.id_ex_alusrc_o, bus.id_ex_rd_o, bus.id_ex_rs_o}, {1'b1, 3'd2, 3'd1}); else n_pass++;
    n_checks++; if ({bus.ex_wb_regwrite_o, bus.ex_wb_rd_o} !== {1'b1, 3'd2}) $display("[TB] FAIL add_wb got %0h exp %0h", {bus.ex_wb_regwrite_o, bus.ex_wb_rd_o}, {1'b1, 3'd2}); else n_pass++;
    drain();
    drive(0, 1, 8'h13, 0); tick();
    drive(0, 1, 8'hC0, 0); tick();
    drive(0, 1, 8'h51, 0); tick();
    drive(0, 1, 8'hC0, 0); tick();
    n_checks++; if (bus.fwd_ctrl_o !== 1'b0) $display("[TB] FAIL fwd_bubble got %0b exp 0", bus.fwd_ctrl_o); else n_pass++;
    n_checks++; if (bus.id_ex_alusrc_o !== 1'b1) $display("[TB] FAIL fwd_bubble alusrc got %0b exp 1", bus.id_ex_alusrc_o); else n_pass++;
  endtask

  task automatic test_jump();
    int cnt0;
    drain();
    cnt0 = m_cnt;
    drive(0, 1, 8'h84, 0); tick();
    drive(0, 1, 8'h13, 0);
    n_checks++; if (bus.pc_load_o !== 1'b1) $display("[TB] FAIL jmp pc_load got %0b exp 1", bus.pc_load_o); else n_pass++;
    n_checks++; if (bus.jump_off_o !== 6'h04) $display("[TB] FAIL jmp offset got %0h exp 04", bus.jump_off_o); else n_pass++;
    tick();
    drive(0, 1, 8'hC0, 0);
    n_checks++; if (bus.pc_load_o !== 1'b0) $display("[TB] FAIL jmp pulse_len got %0b exp 0", bus.pc_load_o); else n_pass++;
    n_checks++; if (bus.jump_off_o !== 6'd0) $display("[TB] FAIL jmp off_idle got %0h exp 0", bus.jump_off_o); else n_pass++;
    n_checks++; if (bus.ifid_valid_o !== 1'b0) $display("[TB] FAIL jmp flushed_slot got %0b exp 0", bus.ifid_valid_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.id_ex_regwrite_o !== 1'b0) $display("[TB] FAIL jmp shadow_in_ex cyc %0d got %0b exp 0", i, bus.id_ex_regwrite_o); else n_pass++;
    end
    n_checks++; if (bus.retire_cnt_o !== RW'(cnt0)) $display("[TB] FAIL jmp retire got %0d exp %0d", bus.retire_cnt_o, cnt0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drain();
    drive(0, 1, 8'h84, 0); tick();
    drive(0, 1, 8'h82, 0);
    n_checks++; if ({bus.pc_load_o, bus.jump_off_o} !== {1'b1, 6'h04}) $display("[TB] FAIL b2b first_jump got %0h exp %0h", {bus.pc_load_o, bus.jump_off_o}, {1'b1, 6'h04}); else n_pass++;
    tick();
    drive(0, 1, 8'hC0, 0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (bus.pc_load_o !== 1'b0) $display("[TB] FAIL b2b second_jump cyc %0d got %0b exp 0", i, bus.pc_load_o); else n_pass++;
      tick();
    end
  endtask

  task automatic test_stall();
    int cnt0;
    drain();
    drive(0, 1, 8'h13, 0); tick();
    drive(0, 1, 8'h51, 0); tick();
    drive(0, 1, 8'h84, 0); tick();
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'h13, 0);
      n_checks++; if (bus.pc_load_o !== 1'b0) $display("[TB] FAIL stall pc_load cyc %0d got %0b exp 0", i, bus.pc_load_o); else n_pass++;
      tick();
      n_checks++; if ({bus.id_ex_regwrite_o, bus.id_ex_alusrc_o, bus.id_ex_rd_o, bus.id_ex_rs_o} !== {2'b11, 3'd2, 3'd1}) $display("[TB] FAIL stall id_ex cyc %0d got %0h exp %0h", i, {bus.id_ex_regwrite_o, bus.id_ex_alusrc_o, bus.id_ex_rd_o, bus.id_ex_rs_o}, {2'b11, 3'd2, 3'd1}); else n_pass++;
      n_checks++; if ({bus.fwd_ctrl_o, bus.ex_wb_regwrite_o, bus.ex_wb_rd_o} !== {2'b11, 3'd2}) $display("[TB] FAIL stall fwd/ex_wb cyc %0d got %0h exp %0h", i, {bus.fwd_ctrl_o, bus.ex_wb_regwrite_o, bus.ex_wb_rd_o}, {2'b11, 3'd2}); else n_pass++;
      n_checks++; if (bus.retire_cnt_o !== RW'(cnt0)) $display("[TB] FAIL stall retire cyc %0d got %0d exp %0d", i, bus.retire_cnt_o, cnt0); else n_pass++;
    end
    drive(0, 1, 8'hC0, 0);
    n_checks++; if ({bus.pc_load_o, bus.jump_off_o} !== {1'b1, 6'h04}) $display("[TB] FAIL stall deferred_jump got %0h exp %0h", {bus.pc_load_o, bus.jump_off_o}, {1'b1, 6'h04}); else n_pass++;
    tick();
    drive(0, 1, 8'hC0, 0);
    n_checks++; if (bus.pc_load_o !== 1'b0) $display("[TB] FAIL stall jump_once got %0b exp 0", bus.pc_load_o); else n_pass++;
    tick();
  endtask

  task automatic test_counter();
    drive(0, 0, 8'hC0, 1); tick();
    n_checks++; if (bus.retire_cnt_o !== 4'd0) $display("[TB] FAIL cnt clear got %0d exp 0", bus.retire_cnt_o); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8'h13, 0);
      tick();
    end
    drain();
    n_checks++; if (bus.retire_cnt_o !== 4'd15) $display("[TB] FAIL cnt saturate got %0d exp 15", bus.retire_cnt_o); else n_pass++;
    repeat (3) begin
      drive(0, 1, 8'h13, 0);
      tick();
    end
    drive(0, 1, 8'h13, 1);
    n_checks++; if (bus.ex_wb_regwrite_o !== 1'b1) $display("[TB] FAIL cnt retire_pending got %0b exp 1", bus.ex_wb_regwrite_o); else n_pass++;
    tick();
    n_checks++; if (bus.retire_cnt_o !== 4'd0) $display("[TB] FAIL cnt clr_over_inc got %0d exp 0", bus.retire_cnt_o); else n_pass++;
    drive(0, 1, 8'hC0, 0); tick();
    n_checks++; if (bus.retire_cnt_o !== 4'd1) $display("[TB] FAIL cnt after_clr got %0d exp 1", bus.retire_cnt_o); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(0, 1, 8'h13, 0); tick();
    drive(0, 1, 8'h51, 0); tick();
    drive(0, 1, 8'h13, 0); tick();
    drive(0, 1, 8'h13, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.ifid_valid_o !== 1'b0) $display("[TB] FAIL arst ifid_valid got %0b exp 0", bus.ifid_valid_o); else n_pass++;
    n_checks++; if ({bus.id_ex_regwrite_o, bus.id_ex_alusrc_o, bus.id_ex_rd_o, bus.id_ex_rs_o} !== 8'd0) $display("[TB] FAIL arst id_ex got %0h exp 0", {bus.id_ex_regwrite_o, bus.id_ex_alusrc_o, bus.id_ex_rd_o, bus.id_ex_rs_o}); else n_pass++;
    n_checks++; if ({bus.fwd_ctrl_o, bus.ex_wb_regwrite_o, bus.ex_wb_rd_o} !== 5'd0) $display("[TB] FAIL arst fwd/ex_wb got %0h exp 0", {bus.fwd_ctrl_o, bus.ex_wb_regwrite_o, bus.ex_wb_rd_o}); else n_pass++;
    n_checks++; if (bus.retire_cnt_o !== 4'd0) $display("[TB] FAIL arst retire got %0d exp 0", bus.retire_cnt_o); else n_pass++;
    model_reset();
    tick();
    rst_n = 1'b1;
    drive(0, 1, 8'h13, 0);
    n_checks++; if (bus.ifid_valid_o !== 1'b0) $display("[TB] FAIL arst refetch got %0b exp 0", bus.ifid_valid_o); else n_pass++;
    tick();
    n_checks++; if ({bus.ifid_valid_o, bus.id_ex_regwrite_o} !== 2'b10) $display("[TB] FAIL arst first_edge got %0b exp 10", {bus.ifid_valid_o, bus.id_ex_regwrite_o}); else n_pass++;
    drive(0, 1, 8'hC0, 0); tick();
    n_checks++; if (bus.id_ex_regwrite_o !== 1'b1) $display("[TB] FAIL arst second_edge got %0b exp 1", bus.id_ex_regwrite_o); else n_pass++;
  endtask

  task automatic test_random();
    bit         st, v, clr;
    logic [7:0] ins;
    for (int c = 0; c < 400; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      v   = ($urandom_range(0, 4) != 0);
      ins = 8'($urandom);
      clr = ($urandom_range(0, 19) == 0);
      drive(st, v, ins, clr);
      n_checks++; if (bus.pc_load_o !== m_pc_load()) $display("[TB] FAIL rnd pc_load cyc %0d got %0b exp %0b", c, bus.pc_load_o, m_pc_load()); else n_pass++;
      n_checks++; if (bus.jump_off_o !== m_jump_off()) $display("[TB] FAIL rnd jump_off cyc %0d got %0h exp %0h", c, bus.jump_off_o, m_jump_off()); else n_pass++;
      n_checks++; if (bus.ifid_valid_o !== m_id_v) $display("[TB] FAIL rnd ifid_valid cyc %0d got %0b exp %0b", c, bus.ifid_valid_o, m_id_v); else n_pass++;
      n_checks++; if ({bus.id_ex_regwrite_o, bus.id_ex_alusrc_o} !== {m_ex_rw, m_ex_src}) $display("[TB] FAIL rnd id_ex_ctl cyc %0d got %0b exp %0b", c, {bus.id_ex_regwrite_o, bus.id_ex_alusrc_o}, {m_ex_rw, m_ex_src}); else n_pass++;
      n_checks++; if ({bus.id_ex_rd_o, bus.id_ex_rs_o} !== {m_ex_rd, m_ex_rs}) $display("[TB] FAIL rnd id_ex_regs cyc %0d got %0h exp %0h", c, {bus.id_ex_rd_o, bus.id_ex_rs_o}, {m_ex_rd, m_ex_rs}); else n_pass++;
      n_checks++; if (bus.fwd_ctrl_o !== m_fwd) $display("[TB] FAIL rnd fwd cyc %0d got %0b exp %0b", c, bus.fwd_ctrl_o, m_fwd); else n_pass++;
      n_checks++; if ({bus.ex_wb_regwrite_o, bus.ex_wb_rd_o} !== {m_wb_rw, m_wb_rd}) $display("[TB] FAIL rnd ex_wb cyc %0d got %0h exp %0h", c, {bus.ex_wb_regwrite_o, bus.ex_wb_rd_o}, {m_wb_rw, m_wb_rd}); else n_pass++;
      n_checks++; if (bus.retire_cnt_o !== RW'(m_cnt)) $display("[TB] FAIL rnd retire cyc %0d got %0d exp %0d", c, bus.retire_cnt_o, m_cnt); else n_pass++;
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.stall_i      = 1'b0;
    bus.if_valid_i   = 1'b0;
    bus.if_instr_i   = 8'h00;
    bus.retire_clr_i = 1'b0;
    model_reset();
    $display("[TB] starting exu_pipeline_ctrl bench");
    test_reset();
    test_forward();
    test_jump();
    test_back_to_back();
    test_stall();
    test_counter();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
